// File: rtl/cic_comp_fir.sv
// Time-multiplexed CIC droop-compensation FIR: one multiplier, one tap per clock, loadable coefficients.
// Define CICCOMP_SATURATE_EN to clamp the output instead of wrapping it.
module cic_comp_fir #(
  parameter int num_taps        = 15,
  parameter int num_bits_input  = 16,
  parameter int num_bits_coef   = 18,
  parameter int num_bits_output = 16,
  parameter int output_shift    = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              tick_i,
  input  logic signed [num_bits_input-1:0]  signal_i,
  input  logic                              coef_we_i,
  input  logic [$clog2(num_taps)-1:0]       coef_addr_i,
  input  logic signed [num_bits_coef-1:0]   coef_data_i,
  output logic                              tick_o,
  output logic signed [num_bits_output-1:0] signal_o,
  output logic                              busy_o,
  output logic                              overrun_o
);

  localparam int PTR_W  = $clog2(num_taps);
  localparam int PROD_W = num_bits_input + num_bits_coef;
  localparam int ACC_W  = num_bits_input + num_bits_coef + PTR_W;

  localparam logic [PTR_W-1:0]  LAST    = PTR_W'(num_taps - 1);
  localparam logic [PTR_W-1:0]  NTAPS   = PTR_W'(num_taps);
  localparam int unsigned       CENTER  = (num_taps - 1) / 2;
  localparam logic signed [num_bits_coef-1:0] COEF_ONE = num_bits_coef'(2 ** output_shift);
  localparam logic signed [ACC_W:0] RND =
    {{(ACC_W - output_shift + 1){1'b0}}, 1'b1, {(output_shift - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state_q, state_d;

  logic signed [num_bits_input-1:0]  dline_q [num_taps];
  logic signed [num_bits_coef-1:0]   coef_q  [num_taps];
  logic [PTR_W-1:0]                  wr_ptr_q;
  logic [PTR_W-1:0]                  newest_q;
  logic [PTR_W-1:0]                  k_q;
  logic signed [ACC_W-1:0]           acc_q;
  logic                              tick_q;
  logic signed [num_bits_output-1:0] signal_q, signal_d;
  logic                              overrun_q;

  logic                              accept;
  logic                              coef_wr;
  logic                              acc_en;
  logic                              out_en;
  logic [PTR_W-1:0]                  rd_idx;
  logic signed [PROD_W-1:0]          prod;
  logic signed [ACC_W:0]             acc_rnd;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick_i) state_d = MAC;
      MAC:     if (k_q == LAST) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / enables ----------------
  always_comb begin
    busy_o  = (state_q != IDLE);
    accept  = tick_i && (state_q == IDLE);
    coef_wr = coef_we_i && (state_q == IDLE) && (coef_addr_i <= LAST);
    acc_en  = (state_q == MAC);
    out_en  = (state_q == OUT);
  end

  // Walk backwards from the newest sample, wrapping below zero.
  always_comb begin
    if (newest_q >= k_q) rd_idx = newest_q - k_q;
    else                 rd_idx = newest_q + NTAPS - k_q;
  end

  assign prod    = dline_q[rd_idx] * coef_q[k_q];
  assign acc_rnd = {acc_q[ACC_W-1], acc_q} + RND;

`ifdef CICCOMP_SATURATE_EN
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(2 ** (num_bits_output - 1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
  logic signed [ACC_W:0] r;
  always_comb begin
    r = acc_rnd >>> output_shift;
    if (r > SAT_MAX)      signal_d = num_bits_output'(SAT_MAX);
    else if (r < SAT_MIN) signal_d = num_bits_output'(SAT_MIN);
    else                  signal_d = num_bits_output'(r);
  end
`else
  always_comb begin
    signal_d = num_bits_output'(acc_rnd >>> output_shift);
  end
`endif

  // ---------------- delay line ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < num_taps; i++) dline_q[i] <= '0;
      wr_ptr_q <= '0;
      newest_q <= '0;
    end else if (accept) begin
      dline_q[wr_ptr_q] <= signal_i;
      newest_q          <= wr_ptr_q;
      wr_ptr_q          <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
  end

  // ---------------- coefficients ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < num_taps; i++)
        coef_q[i] <= (i == CENTER) ? COEF_ONE : '0;
    end else if (coef_wr) begin
      coef_q[coef_addr_i] <= coef_data_i;
    end
  end

  // ---------------- MAC datapath ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q   <= '0;
      acc_q <= '0;
    end else if (accept) begin
      k_q   <= '0;
      acc_q <= '0;
    end else if (acc_en) begin
      acc_q <= acc_q + ACC_W'(prod);
      if (k_q != LAST) k_q <= k_q + PTR_W'(1);
    end
  end

  // ---------------- output and status ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_q    <= 1'b0;
      signal_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      tick_q <= out_en;
      if (out_en) signal_q <= signal_d;
      if (tick_i && busy_o) overrun_q <= 1'b1;
    end
  end

  assign tick_o    = tick_q;
  assign signal_o  = signal_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: stimulus pushes expected outputs, a monitor pops and compares on tick_o.
module tb_cic_comp_fir;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               tick_i;
  logic signed [15:0] signal_i;
  logic               coef_we_i;
  logic [3:0]         coef_addr_i;
  logic signed [17:0] coef_data_i;
  logic               tick_o;
  logic signed [15:0] signal_o;
  logic               busy_o;
  logic               overrun_o;

  cic_comp_fir #(
    .num_taps(15), .num_bits_input(16), .num_bits_coef(18),
    .num_bits_output(16), .output_shift(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .tick_i(tick_i), .signal_i(signal_i),
    .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i),
    .tick_o(tick_o), .signal_o(signal_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct { int val; int cyc; } exp_t;
  exp_t sb[$];
  int   hist[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (tick_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tick_o: got tick with signal_o=%0d, expected no tick", signal_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("signal_o", int'(signal_o), e.val);
        check("latency", cyc - e.cyc, 17);
      end
    end
  end

  task automatic hist_clear();
    hist.delete();
    for (int i = 0; i < 15; i++) hist.push_back(0);
  endtask

  task automatic wr_coef(input int a, input int d);
    @(posedge clk); #1;
    coef_we_i = 1'b1; coef_addr_i = 4'(a); coef_data_i = 18'(d);
    @(posedge clk); #1;
    coef_we_i = 1'b0;
  endtask

  task automatic load_all(input int d);
    for (int i = 0; i < 15; i++) wr_coef(i, d);
  endtask

  task automatic load_impulse();
    for (int i = 0; i < 15; i++) wr_coef(i, (i == 7) ? 65536 : 0);
  endtask

  // One tick; if acc the sample is expected to be accepted with result e.
  task automatic send(input int x, input int e, input bit acc, input int gap,
                      input bit we, input int wd, input bit mid_wr);
    int rem;
    @(posedge clk); #1;
    tick_i = 1'b1; signal_i = 16'(x);
    if (we) begin coef_we_i = 1'b1; coef_addr_i = 4'd7; coef_data_i = 18'(wd); end
    @(negedge clk);
    if (acc) begin
      sb.push_back('{e, cyc});
      hist.push_back(x);
      void'(hist.pop_front());
    end
    @(posedge clk); #1;
    tick_i = 1'b0; coef_we_i = 1'b0;
    rem = gap - 2;
    if (mid_wr) begin
      repeat (3) @(posedge clk);
      #1;
      check("busy_during_mac", int'(busy_o), 1);
      coef_we_i = 1'b1; coef_addr_i = 4'd7; coef_data_i = '0;
      @(posedge clk); #1;
      coef_we_i = 1'b0;
      rem -= 4;
    end
    repeat (rem) @(posedge clk);
  endtask

  // Impulse coefficient set: output equals the sample seven accepted ticks back (hist[8] before the push).
  task automatic send_imp(input int x, input int gap);
    send(x, hist[8], 1'b1, gap, 1'b0, 0, 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
    check(name, sb.size(), 0);
  endtask

  task automatic test_impulse();
    for (int i = 0; i < 16; i++)
      send((i == 0) ? 1000 : 0, (i == 7) ? 1000 : 0, 1'b1, 20, 1'b0, 0, 1'b0);
  endtask

  task automatic test_step();
    load_all(4096);
    for (int i = 0; i < 16; i++)
      send(16384, 1024 * ((i + 1 > 15) ? 15 : i + 1), 1'b1, 20, 1'b0, 0, 1'b0);
  endtask

  task automatic test_large();
    int k, v, e;
    logic [15:0] w;
    load_all(65536);
    for (int i = 0; i < 16; i++) begin
      k = (i + 1 > 15) ? 15 : i + 1;
      v = k * 32767 + (15 - k) * 16384;
      w = 16'(v);
`ifdef CICCOMP_SATURATE_EN
      e = 32767;
`else
      e = int'($signed(w));
`endif
      send(32767, e, 1'b1, 20, 1'b0, 0, 1'b0);
    end
  endtask

  task automatic test_overrun();
    load_impulse();
    for (int i = 0; i < 15; i++) send_imp(0, 20);
    @(negedge clk);
    check("overrun_before_drop", int'(overrun_o), 0);
    send_imp(100, 10);
    send(555, 0, 1'b0, 10, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("overrun_after_drop", int'(overrun_o), 1);
    send_imp(200, 10);
    send(666, 0, 1'b0, 10, 1'b0, 0, 1'b0);
    send_imp(300, 20);
    for (int i = 0; i < 8; i++) send_imp(0, 20);
    @(negedge clk);
    check("overrun_sticky", int'(overrun_o), 1);
  endtask

  // Same-cycle coefficient write lands for the MAC it starts; also exercises half-up rounding.
  task automatic test_round();
    send_imp(3, 20);
    send_imp(-3, 20);
    for (int i = 0; i < 5; i++) send_imp(0, 20);
    send(0, 2, 1'b1, 20, 1'b1, 32768, 1'b0);
    send(0, -1, 1'b1, 20, 1'b0, 0, 1'b0);
    wr_coef(7, 65536);
  endtask

  task automatic test_busy_write();
    send(1000, hist[8], 1'b1, 20, 1'b0, 0, 1'b1);
    for (int i = 0; i < 8; i++) send_imp(0, 20);
  endtask

  task automatic test_reset_mid_mac();
    drain("drain_before_reset");
    @(posedge clk); #1;
    tick_i = 1'b1; signal_i = 16'sd1234;
    @(posedge clk); #1;
    tick_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_signal_o", int'(signal_o), 0);
    check("rst_busy_o", int'(busy_o), 0);
    check("rst_overrun_o", int'(overrun_o), 0);
    check("rst_tick_o", int'(tick_o), 0);
    repeat (25) @(posedge clk);
    hist_clear();
    for (int i = 0; i < 9; i++)
      send((i == 0) ? 1000 : 0, (i == 7) ? 1000 : 0, 1'b1, 20, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; tick_i = 1'b0; signal_i = '0;
    coef_we_i = 1'b0; coef_addr_i = '0; coef_data_i = '0;
    hist_clear();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset_tick_o", int'(tick_o), 0);
    check("reset_signal_o", int'(signal_o), 0);
    check("reset_busy_o", int'(busy_o), 0);
    check("reset_overrun_o", int'(overrun_o), 0);

    test_impulse();
    test_step();
    test_large();
    test_overrun();
    test_round();
    test_busy_write();
    test_reset_mid_mac();
    drain("drain_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
